// File: rtl/meteor_field.sv
`default_nettype none
// ============================================================================
//  Module   : meteor_field
//  Purpose  : Multi-slot meteor manager. Each slot runs an IDLE/ACTIVE/EXPLODE
//             state machine stepped once per video frame. Handles staggered
//             single-slot spawning, bullet collisions with multi-hit health,
//             explosion hold time and escape/score pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module meteor_field #(
  parameter int OBJ_NUM        = 8,
  parameter int COORD_W        = 10,
  parameter int OBJ_SIZE       = 30,
  parameter int HP_INIT        = 2,
  parameter int BASE_VY        = 2,
  parameter int X_MIN          = 25,
  parameter int X_MAX          = 605,
  parameter int Y_MAX          = 481,
  parameter int EXPLODE_FRAMES = 8,
  parameter int RESPAWN_GAP    = 4
) (
  input  logic               frame_clk,
  input  logic               Reset_n,
  input  logic               enable,
  input  logic [COORD_W-1:0] spawn_x,
  input  logic [4:0]         spawn_vx,
  input  logic [4:0]         spawn_vy,
  input  logic               spawn_sign,
  input  logic               ammo_valid,
  input  logic [COORD_W-1:0] ammo_x,
  input  logic [COORD_W-1:0] ammo_y,
  output logic               bullet_hit,
  output logic [3:0]         hit_index,
  output logic               score_inc,
  output logic               escaped,
  output logic [COORD_W-1:0] obj_x         [OBJ_NUM],
  output logic [COORD_W-1:0] obj_y         [OBJ_NUM],
  output logic               obj_active    [OBJ_NUM],
  output logic               obj_exploding [OBJ_NUM],
  output logic [2:0]         obj_hp        [OBJ_NUM],
  output logic [COORD_W-1:0] obj_size      [OBJ_NUM]
);

  // State encoding chosen so that bit 0 is "active" and bit 1 is "exploding";
  // the status outputs are then plain register bits.
  localparam logic [1:0] IDLE    = 2'b00;
  localparam logic [1:0] ACTIVE  = 2'b01;
  localparam logic [1:0] EXPLODE = 2'b10;

  // The shared counter must hold the largest reset stagger, the explosion
  // hold and the respawn gap.
  localparam int STAGGER_MAX = (OBJ_NUM - 1) * RESPAWN_GAP;
  localparam int CNT_MAX0    = (STAGGER_MAX > EXPLODE_FRAMES) ? STAGGER_MAX : EXPLODE_FRAMES;
  localparam int CNT_MAX     = (CNT_MAX0 > RESPAWN_GAP) ? CNT_MAX0 : RESPAWN_GAP;
  localparam int CNT_W       = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [COORD_W-1:0] X_LO     = COORD_W'(X_MIN);
  localparam logic [COORD_W-1:0] X_HI     = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] SIZE_C   = COORD_W'(OBJ_SIZE);
  localparam logic [COORD_W-1:0] VY_BASE  = COORD_W'(BASE_VY);
  localparam logic [COORD_W:0]   Y_HI     = (COORD_W + 1)'(Y_MAX);
  localparam logic [COORD_W:0]   SIZE_EXT = (COORD_W + 1)'(OBJ_SIZE);
  localparam logic [CNT_W-1:0]   GAP_CNT  = CNT_W'(RESPAWN_GAP);
  localparam logic [CNT_W-1:0]   BOOM_CNT = CNT_W'(EXPLODE_FRAMES - 1);
  localparam logic [2:0]         HP_START = 3'(HP_INIT);

  logic [1:0]         state [OBJ_NUM];
  logic [CNT_W-1:0]   cnt   [OBJ_NUM];
  logic [COORD_W-1:0] vx    [OBJ_NUM];
  logic [COORD_W-1:0] vy    [OBJ_NUM];
  logic [COORD_W-1:0] nx    [OBJ_NUM];
  logic [COORD_W:0]   ny    [OBJ_NUM];
  logic [OBJ_NUM-1:0] collide;
  logic [OBJ_NUM-1:0] is_hit;
  logic [OBJ_NUM-1:0] retire_x;
  logic [OBJ_NUM-1:0] escape;
  logic               hit_found;
  logic [3:0]         hit_sel;
  logic               spawn_found;
  logic [3:0]         spawn_sel;
  logic               kill;
  logic [COORD_W-1:0] spawn_vx_mag;
  logic [COORD_W-1:0] spawn_vx_val;
  logic [COORD_W-1:0] spawn_vy_val;

  // Spawn velocity: vx is stored two's complement so leftward motion wraps.
  always_comb begin
    spawn_vx_mag = COORD_W'(spawn_vx);
    spawn_vx_val = spawn_sign ? -spawn_vx_mag : spawn_vx_mag;
    spawn_vy_val = VY_BASE + COORD_W'(spawn_vy);
  end

  // Per-slot collision / next position, lowest-index hit and spawn selection.
  always_comb begin
    collide     = '0;
    is_hit      = '0;
    retire_x    = '0;
    escape      = '0;
    hit_found   = 1'b0;
    hit_sel     = 4'd0;
    spawn_found = 1'b0;
    spawn_sel   = 4'd0;
    for (int i = 0; i < OBJ_NUM; i++) begin
      nx[i] = obj_x[i] + vx[i];
      ny[i] = {1'b0, obj_y[i]} + {1'b0, vy[i]};
      collide[i] = ammo_valid && (state[i] == ACTIVE)
                && (ammo_x > obj_x[i]) && ({1'b0, ammo_x} < ({1'b0, obj_x[i]} + SIZE_EXT))
                && (ammo_y > obj_y[i]) && ({1'b0, ammo_y} < ({1'b0, obj_y[i]} + SIZE_EXT));
      if (collide[i] && !hit_found) begin
        hit_found = 1'b1;
        hit_sel   = 4'(i);
      end
      if (!spawn_found && (state[i] == IDLE) && (cnt[i] == '0)) begin
        spawn_found = 1'b1;
        spawn_sel   = 4'(i);
      end
    end
    for (int i = 0; i < OBJ_NUM; i++) begin
      is_hit[i]   = hit_found && (hit_sel == 4'(i));
      retire_x[i] = (nx[i] < X_LO) || (nx[i] > X_HI);
      escape[i]   = (state[i] == ACTIVE) && !is_hit[i] && !retire_x[i] && (ny[i] > Y_HI);
    end
    kill = hit_found && (obj_hp[hit_sel] == 3'd1);
  end

  // Status outputs come straight from state register bits; size is constant.
  always_comb begin
    for (int i = 0; i < OBJ_NUM; i++) begin
      obj_active[i]    = state[i][0];
      obj_exploding[i] = state[i][1];
      obj_size[i]      = SIZE_C;
    end
  end

  // Per-slot state machines, one step per enabled frame.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < OBJ_NUM; i++) begin
        state[i]  <= IDLE;
        cnt[i]    <= CNT_W'(i * RESPAWN_GAP);
        obj_x[i]  <= '0;
        obj_y[i]  <= '0;
        vx[i]     <= '0;
        vy[i]     <= '0;
        obj_hp[i] <= 3'd0;
      end
    end else if (enable) begin
      for (int i = 0; i < OBJ_NUM; i++) begin
        case (state[i])
          IDLE: begin
            if (cnt[i] != '0) begin
              cnt[i] <= cnt[i] - 1'b1;
            end else if (spawn_found && (spawn_sel == 4'(i))) begin
              state[i]  <= ACTIVE;
              obj_x[i]  <= spawn_x;
              obj_y[i]  <= '0;
              vx[i]     <= spawn_vx_val;
              vy[i]     <= spawn_vy_val;
              obj_hp[i] <= HP_START;
            end
          end
          ACTIVE: begin
            if (is_hit[i]) begin
              // A hit freezes the meteor for this frame, even at a boundary.
              obj_hp[i] <= obj_hp[i] - 3'd1;
              if (obj_hp[i] == 3'd1) begin
                state[i] <= EXPLODE;
                cnt[i]   <= BOOM_CNT;
              end
            end else if (retire_x[i] || (ny[i] > Y_HI)) begin
              state[i] <= IDLE;
              cnt[i]   <= GAP_CNT;
            end else begin
              obj_x[i] <= nx[i];
              obj_y[i] <= ny[i][COORD_W-1:0];
            end
          end
          EXPLODE: begin
            if (cnt[i] == '0) begin
              state[i]  <= IDLE;
              cnt[i]    <= GAP_CNT;
              obj_hp[i] <= 3'd0;
            end else begin
              cnt[i] <= cnt[i] - 1'b1;
            end
          end
          default: state[i] <= IDLE;
        endcase
      end
    end
  end

  // Event pulses: one frame wide, several same-frame events merge into one.
  always_ff @(posedge frame_clk or negedge Reset_n) begin
    if (!Reset_n) begin
      bullet_hit <= 1'b0;
      hit_index  <= 4'd0;
      score_inc  <= 1'b0;
      escaped    <= 1'b0;
    end else if (enable) begin
      bullet_hit <= hit_found;
      hit_index  <= hit_found ? hit_sel : 4'd0;
      score_inc  <= kill;
      escaped    <= |escape;
    end else begin
      bullet_hit <= 1'b0;
      score_inc  <= 1'b0;
      escaped    <= 1'b0;
    end
  end

endmodule
`default_nettype wire
